// File: rtl/mmu_pager_pkg.sv
// Shared types for the paged address translator: FSM states, default geometry
// and the logical-address split helper.
package mmu_pager_pkg;

    localparam int ADDR_W_DEF    = 10;
    localparam int PAGE_BITS_DEF = 3;
    localparam int PROCS_DEF     = 8;
    localparam int PG_W_DEF      = ADDR_W_DEF - PAGE_BITS_DEF;

    typedef enum logic [2:0] {IDLE, WALK, ALLOC, RESP, RELEASE} state_e;

    typedef struct packed {
        logic [PG_W_DEF-1:0]      page;
        logic [PAGE_BITS_DEF-1:0] offset;
    } laddr_split_t;

    function automatic laddr_split_t split_laddr(input logic [ADDR_W_DEF-1:0] laddr);
        return laddr_split_t'(laddr);
    endfunction

endpackage

// File: rtl/mmu_pager_free_scan.sv
// Free-page scanner: walks the used bitmap one page per cycle from a start
// index, wrapping modulo the page count, and flags a free page or exhaustion.
module mmu_free_scan
    import mmu_pager_pkg::*;
#(
    parameter int PG_W = PG_W_DEF
) (
    input  logic                 clka,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [PG_W-1:0]      start_idx_i,
    input  logic                 en_i,
    input  logic [2**PG_W-1:0]   used_i,
    output logic [PG_W-1:0]      idx_o,
    output logic                 found_o,
    output logic                 exhausted_o
);

    logic [PG_W-1:0] idx_q, idx_d;
    logic [PG_W-1:0] cnt_q, cnt_d;

    assign idx_o       = idx_q;
    assign found_o     = en_i && !used_i[idx_q];
    // cnt_q counts pages already rejected, so all-ones means this is the last candidate.
    assign exhausted_o = en_i && used_i[idx_q] && (&cnt_q);

    always_comb begin
        idx_d = idx_q;
        cnt_d = cnt_q;
        if (start_i) begin
            idx_d = start_idx_i;
            cnt_d = '0;
        end else if (en_i && !found_o) begin
            idx_d = idx_q + PG_W'(1);
            cnt_d = cnt_q + PG_W'(1);
        end
    end

    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            idx_q <= '0;
            cnt_q <= '0;
        end else begin
            idx_q <= idx_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mmu_pager.sv
// Per-process paged address translator with linked page chains, first-touch
// allocation and bulk release. Optional per-process cache: MMU_PAGER_CACHE_EN.
module mmu_pager
    import mmu_pager_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int PAGE_BITS = PAGE_BITS_DEF,
    parameter int PROCS     = PROCS_DEF,
    localparam int PID_W    = $clog2(PROCS),
    localparam int PG_W     = ADDR_W - PAGE_BITS,
    localparam int PAGES    = 2**PG_W
) (
    input  logic              clka,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [PID_W-1:0]  req_pid_i,
    input  logic [ADDR_W-1:0] req_laddr_i,
    input  logic              rel_valid_i,
    input  logic [PID_W-1:0]  rel_pid_i,
    output logic              rsp_valid_o,
    output logic [ADDR_W-1:0] rsp_paddr_o,
    output logic              rsp_fault_o,
    output logic              rel_done_o
);

    state_e state_q, state_d;

    logic [PAGES-1:0]     used_q;
    logic [PG_W-1:0]      next_q  [PAGES];
    logic [PG_W-1:0]      lpage_q [PAGES];
    logic [PROCS-1:0]     head_valid_q;
    logic [PG_W-1:0]      head_q  [PROCS];

    logic [PG_W-1:0]      free_ptr_q, free_ptr_d;
    logic [PID_W-1:0]     pid_q, pid_d;
    logic [PG_W-1:0]      lp_q, lp_d;
    logic [PAGE_BITS-1:0] off_q, off_d;
    logic [PG_W-1:0]      cur_q, cur_d;
    logic [PG_W-1:0]      tail_q, tail_d;
    logic                 has_tail_q, has_tail_d;
    logic [PG_W-1:0]      pg_q, pg_d;
    logic                 fault_q, fault_d;
    logic                 rel_fin_q, rel_fin_d;

    logic                 rsp_valid_q, rsp_fault_q, rel_done_q;
    logic [ADDR_W-1:0]    rsp_paddr_q;

    logic                 scan_start, alloc_we, rel_clear, rsp_fire;
    logic                 scan_found, scan_exhausted;
    logic [PG_W-1:0]      scan_idx;
    logic                 cur_tail;
    logic                 cache_hit;
    logic [PG_W-1:0]      cache_pg;
    laddr_split_t         req_split;

    assign req_split = split_laddr(req_laddr_i);
    assign cur_tail  = (next_q[cur_q] == cur_q);

    mmu_free_scan #(.PG_W(PG_W)) u_scan (
        .clka        (clka),
        .rst         (rst),
        .start_i     (scan_start),
        .start_idx_i (free_ptr_q),
        .en_i        (state_q == ALLOC),
        .used_i      (used_q),
        .idx_o       (scan_idx),
        .found_o     (scan_found),
        .exhausted_o (scan_exhausted)
    );

`ifdef MMU_PAGER_CACHE_EN
    logic [PROCS-1:0] cache_valid_q;
    logic [PG_W-1:0]  cache_lp_q [PROCS];
    logic [PG_W-1:0]  cache_pg_q [PROCS];

    assign cache_hit = cache_valid_q[req_pid_i] && (cache_lp_q[req_pid_i] == req_split.page);
    assign cache_pg  = cache_pg_q[req_pid_i];

    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            cache_valid_q <= '0;
        end else if (rsp_fire && !fault_q) begin
            cache_valid_q[pid_q] <= 1'b1;
        end else if (rel_fin_d) begin
            cache_valid_q[pid_d] <= 1'b0;
        end
    end

    always_ff @(posedge clka) begin
        if (rsp_fire && !fault_q) begin
            cache_lp_q[pid_q] <= lp_q;
            cache_pg_q[pid_q] <= pg_q;
        end
    end
`else
    assign cache_hit = 1'b0;
    assign cache_pg  = '0;
`endif

    // NOTE: every variable gets a default before the case so no path infers a latch.
    always_comb begin
        state_d    = state_q;
        pid_d      = pid_q;
        lp_d       = lp_q;
        off_d      = off_q;
        cur_d      = cur_q;
        tail_d     = tail_q;
        has_tail_d = has_tail_q;
        pg_d       = pg_q;
        fault_d    = fault_q;
        free_ptr_d = free_ptr_q;
        rel_fin_d  = 1'b0;
        scan_start = 1'b0;
        alloc_we   = 1'b0;
        rel_clear  = 1'b0;
        rsp_fire   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rel_fin_q) begin
                    if (rel_valid_i) begin
                        pid_d = rel_pid_i;
                        if (head_valid_q[rel_pid_i]) begin
                            cur_d   = head_q[rel_pid_i];
                            state_d = RELEASE;
                        end else begin
                            rel_fin_d = 1'b1;
                        end
                    end else if (req_valid_i) begin
                        pid_d   = req_pid_i;
                        lp_d    = req_split.page;
                        off_d   = req_split.offset;
                        fault_d = 1'b0;
                        if (cache_hit) begin
                            pg_d    = cache_pg;
                            state_d = RESP;
                        end else if (head_valid_q[req_pid_i]) begin
                            cur_d   = head_q[req_pid_i];
                            state_d = WALK;
                        end else begin
                            has_tail_d = 1'b0;
                            scan_start = 1'b1;
                            state_d    = ALLOC;
                        end
                    end
                end
            end
            WALK: begin
                if (lpage_q[cur_q] == lp_q) begin
                    pg_d    = cur_q;
                    state_d = RESP;
                end else if (cur_tail) begin
                    tail_d     = cur_q;
                    has_tail_d = 1'b1;
                    scan_start = 1'b1;
                    state_d    = ALLOC;
                end else begin
                    cur_d = next_q[cur_q];
                end
            end
            ALLOC: begin
                if (scan_found) begin
                    alloc_we   = 1'b1;
                    pg_d       = scan_idx;
                    free_ptr_d = scan_idx + PG_W'(1);
                    state_d    = RESP;
                end else if (scan_exhausted) begin
                    fault_d = 1'b1;
                    pg_d    = '0;
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_fire = 1'b1;
                state_d  = IDLE;
            end
            RELEASE: begin
                rel_clear = 1'b1;
                if (cur_q < free_ptr_q) free_ptr_d = cur_q;
                if (cur_tail) begin
                    rel_fin_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cur_d = next_q[cur_q];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            used_q       <= '0;
            head_valid_q <= '0;
            free_ptr_q   <= '0;
            pid_q        <= '0;
            lp_q         <= '0;
            off_q        <= '0;
            cur_q        <= '0;
            tail_q       <= '0;
            has_tail_q   <= 1'b0;
            pg_q         <= '0;
            fault_q      <= 1'b0;
            rel_fin_q    <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_fault_q  <= 1'b0;
            rsp_paddr_q  <= '0;
            rel_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            free_ptr_q  <= free_ptr_d;
            pid_q       <= pid_d;
            lp_q        <= lp_d;
            off_q       <= off_d;
            cur_q       <= cur_d;
            tail_q      <= tail_d;
            has_tail_q  <= has_tail_d;
            pg_q        <= pg_d;
            fault_q     <= fault_d;
            rel_fin_q   <= rel_fin_d;
            rsp_valid_q <= rsp_fire;
            rsp_fault_q <= rsp_fire && fault_q;
            rsp_paddr_q <= (rsp_fire && !fault_q) ? {pg_q, off_q} : '0;
            rel_done_q  <= rel_fin_q;
            if (alloc_we) begin
                used_q[scan_idx] <= 1'b1;
                if (!has_tail_q) head_valid_q[pid_q] <= 1'b1;
            end
            if (rel_clear) used_q[cur_q] <= 1'b0;
            if (rel_fin_d) head_valid_q[pid_d] <= 1'b0;
        end
    end

    // NOTE: link/lpage/head storage is qualified by used/head_valid, so it needs no reset.
    always_ff @(posedge clka) begin
        if (alloc_we) begin
            lpage_q[scan_idx] <= lp_q;
            next_q[scan_idx]  <= scan_idx;
            if (has_tail_q) next_q[tail_q] <= scan_idx;
            else            head_q[pid_q]  <= scan_idx;
        end
    end

    assign req_ready_o = (state_q == IDLE) && !rel_fin_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_paddr_o = rsp_paddr_q;
    assign rsp_fault_o = rsp_fault_q;
    assign rel_done_o  = rel_done_q;

endmodule
